// File: rtl/tohost_pkg.sv
// Shared types and the tohost decode rule for the riscv-tests completion responder.
`timescale 1ns/1ps
package tohost_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_e;

  typedef enum logic [1:0] {
    DEC_IGNORE,
    DEC_PASS,
    DEC_FAIL
  } decode_e;

  localparam logic [31:0] TOHOST_PASS_CODE = 32'h0000_0001;
  localparam logic [3:0]  FULL_STRB        = 4'hF;

  // Only a full-word write with bit 0 set ends a test; bit 0 clear is a syscall request we do not serve.
  function automatic decode_e decode_write(input logic [31:0] addr,
                                           input logic [31:0] data,
                                           input logic [3:0]  strb,
                                           input logic [31:0] tohost_addr);
    decode_e res;
    res = DEC_IGNORE;
    if ((addr == tohost_addr) && (strb == FULL_STRB) && data[0]) begin
      res = (data == TOHOST_PASS_CODE) ? DEC_PASS : DEC_FAIL;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at all ones; synchronous clear has priority over enable.
`timescale 1ns/1ps
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tohost_responder.sv
// Write-bus responder for the tohost convention: decodes the completion word into
// sticky pass/fail/timeout status with run-cycle and ignored-write counters.
`timescale 1ns/1ps
module tohost_responder
  import tohost_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [31:0]      wr_addr_i,
  input  logic [31:0]      wr_data_i,
  input  logic [3:0]       wr_strb_i,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [30:0]      fail_code_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] ignored_count_o
);

  state_e      state_q, state_d;
  logic [30:0] fail_code_q, fail_code_d;
  logic        accept;
  decode_e     dec;
  logic        at_limit;
  logic        cnt_clr;
  logic        cyc_en;
  logic        ign_en;

  assign accept = wr_valid_i & wr_ready_o;
  assign dec    = decode_write(wr_addr_i, wr_data_i, wr_strb_i, TOHOST_ADDR);

  // Compared at 64 bits so a limit beyond the counter range is simply never reached.
  assign at_limit = (64'(cycle_count_o) == (64'(TIMEOUT_CYCLES) - 64'd1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      fail_code_q <= '0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        if (clear_i) begin
          state_d     = ST_IDLE;
          fail_code_d = '0;
        end else if (accept && (dec == DEC_PASS)) begin
          state_d = ST_PASS;
        end else if (accept && (dec == DEC_FAIL)) begin
          state_d     = ST_FAIL;
          fail_code_d = wr_data_i[31:1];
        end else if (at_limit) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (clear_i) begin
          state_d     = ST_IDLE;
          fail_code_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ready_o  = 1'b0;
    done_o      = 1'b0;
    pass_o      = 1'b0;
    timeout_o   = 1'b0;
    fail_code_o = '0;
    case (state_q)
      ST_RUN: wr_ready_o = 1'b1;
      ST_PASS: begin
        wr_ready_o = 1'b1;
        done_o     = 1'b1;
        pass_o     = 1'b1;
      end
      ST_FAIL: begin
        wr_ready_o  = 1'b1;
        done_o      = 1'b1;
        fail_code_o = fail_code_q;
      end
      ST_TIMEOUT: begin
        wr_ready_o = 1'b1;
        done_o     = 1'b1;
        timeout_o  = 1'b1;
      end
      default: ;
    endcase
  end

  // Counters are only non-zero outside IDLE, so gating clear on state keeps IDLE inert.
  assign cnt_clr = clear_i && (state_q != ST_IDLE);
  assign cyc_en  = (state_q == ST_RUN);
  assign ign_en  = (state_q == ST_RUN) && accept && (dec == DEC_IGNORE);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (cnt_clr),
    .en_i    (cyc_en),
    .count_o (cycle_count_o)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_ignored_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (cnt_clr),
    .en_i    (ign_en),
    .count_o (ignored_count_o)
  );

endmodule

// File: tb/tb_tohost_responder.sv
// Scoreboard bench for tohost_responder: a per-cycle behavioural model queues expected
// status, and a monitor compares the DUT outputs one time unit after each rising edge.
`timescale 1ns/1ps
module tb_tohost_responder;

  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int unsigned TMO    = 5000;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        wrValid;
  logic        wrReady;
  logic [31:0] wrAddr;
  logic [31:0] wrData;
  logic [3:0]  wrStrb;
  logic        done;
  logic        pass;
  logic        timeoutOut;
  logic [30:0] failCode;
  logic [31:0] cycleCount;
  logic [31:0] ignoredCount;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          ready;
    bit          done;
    bit          pass;
    bit          tmo;
    logic [30:0] code;
    logic [31:0] cyc;
    logic [31:0] ign;
  } expect_t;

  expect_t expQ[$];

  bit          mRunning, mDone, mPass, mTmo;
  logic [30:0] mCode;
  int unsigned mCyc, mIgn;

  tohost_responder #(
    .TOHOST_ADDR    (TOHOST),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (32)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .wr_valid_i      (wrValid),
    .wr_ready_o      (wrReady),
    .wr_addr_i       (wrAddr),
    .wr_data_i       (wrData),
    .wr_strb_i       (wrStrb),
    .done_o          (done),
    .pass_o          (pass),
    .timeout_o       (timeoutOut),
    .fail_code_o     (failCode),
    .cycle_count_o   (cycleCount),
    .ignored_count_o (ignoredCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s t=%0t actual=%0h required=%0h", name, $time, actual, expected);
    end
  endtask

  task automatic modelZero();
    mRunning = 0; mDone = 0; mPass = 0; mTmo = 0;
    mCode = '0; mCyc = 0; mIgn = 0;
  endtask

  // One clock edge of the test protocol, described as "what a test run means" rather than as states.
  task automatic modelStep(input bit r, input bit c, input bit v,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!r) begin
      modelZero();
    end else if (!mRunning && !mDone) begin
      mRunning = 1;
    end else if (c) begin
      modelZero();
    end else if (mRunning) begin
      if (mCyc != 32'hFFFF_FFFF) mCyc++;
      if (v && a == TOHOST && s == 4'hF && d[0]) begin
        mRunning = 0;
        mDone    = 1;
        if (d == 32'd1) mPass = 1;
        else            mCode = d[31:1];
      end else begin
        if (v && mIgn != 32'hFFFF_FFFF) mIgn++;
        if (mCyc == TMO) begin
          mRunning = 0;
          mDone    = 1;
          mTmo     = 1;
        end
      end
    end
  endtask

  task automatic pushExpect();
    expect_t e;
    e.ready = mRunning || mDone;
    e.done  = mDone;
    e.pass  = mPass;
    e.tmo   = mTmo;
    e.code  = mCode;
    e.cyc   = mCyc;
    e.ign   = mIgn;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit r, input bit c, input bit v,
                               input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    rst_n   = r;
    clear   = c;
    wrValid = v;
    wrAddr  = a;
    wrData  = d;
    wrStrb  = s;
    modelStep(r, c, v, a, d, s);
    pushExpect();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic writeBus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    applyStimulus(1'b1, 1'b0, 1'b1, a, d, s);
  endtask

  task automatic restart();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    idleCycles(1);
  endtask

  task automatic runUntil(input int unsigned target);
    int guard = 0;
    while (mRunning && mCyc < target && guard < 10000) begin
      idleCycles(1);
      guard++;
    end
    if (guard >= 10000) begin
      checks++;
      failures++;
      $display("[TB] FAIL runUntil_bound actual=%0d required=%0d", mCyc, target);
    end
  endtask

  task automatic asyncResetCheck();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_ready", 64'(wrReady), 64'd0);
    checkOutput("async_done", 64'(done), 64'd0);
    checkOutput("async_pass", 64'(pass), 64'd0);
    checkOutput("async_cycle", 64'(cycleCount), 64'd0);
    checkOutput("async_ignored", 64'(ignoredCount), 64'd0);
    clear   = 1'b0;
    wrValid = 1'b0;
    modelStep(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    pushExpect();
    applyStimulus(1'b0, 1'b0, 1'b1, TOHOST, 32'h1, 4'hF);
    @(negedge clk);
    rst_n   = 1'b1;
    wrValid = 1'b0;
    #1;
    checkOutput("ready_after_release", 64'(wrReady), 64'd0);
    modelStep(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    pushExpect();
  endtask

  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("wr_ready", 64'(wrReady), 64'(e.ready));
        checkOutput("done", 64'(done), 64'(e.done));
        checkOutput("pass", 64'(pass), 64'(e.pass));
        checkOutput("timeout", 64'(timeoutOut), 64'(e.tmo));
        checkOutput("fail_code", 64'(failCode), 64'(e.code));
        checkOutput("cycle_count", 64'(cycleCount), 64'(e.cyc));
        checkOutput("ignored_count", 64'(ignoredCount), 64'(e.ign));
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    bit          v;
    bit          c;
    int          pick;

    rst_n = 1'b0; clear = 1'b0; wrValid = 1'b0;
    wrAddr = '0; wrData = '0; wrStrb = '0;
    modelZero();

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, TOHOST, 32'h1, 4'hF);
    idleCycles(1);

    runUntil(9);
    writeBus(TOHOST, 32'h1, 4'hF);
    idleCycles(3);

    restart();
    writeBus(TOHOST, 32'h0000_0007, 4'hF);
    writeBus(TOHOST, 32'h1, 4'hF);
    idleCycles(2);

    restart();
    writeBus(32'h0000_2000, 32'h1, 4'hF);
    writeBus(TOHOST, 32'h1, 4'h3);
    writeBus(TOHOST, 32'h2, 4'hF);
    runUntil(TMO + 10);
    idleCycles(2);
    writeBus(TOHOST, 32'h1, 4'hF);
    idleCycles(1);

    restart();
    runUntil(TMO - 1);
    writeBus(TOHOST, 32'h1, 4'hF);
    idleCycles(2);

    restart();
    writeBus(TOHOST, 32'h5, 4'hF);
    idleCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b1, TOHOST, 32'h1, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    idleCycles(1);
    writeBus(TOHOST, 32'h1, 4'hF);
    idleCycles(2);

    restart();
    writeBus(32'h0000_2000, 32'h3, 4'hF);
    idleCycles(3);
    asyncResetCheck();
    idleCycles(3);

    for (int ep = 0; ep < 40; ep++) begin
      restart();
      for (int k = 0; k < 25; k++) begin
        pick = int'($urandom_range(0, 9));
        if (pick < 5)      a = TOHOST;
        else if (pick < 8) a = 32'h0000_2000;
        else               a = $urandom;
        s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        d = $urandom;
        pick = int'($urandom_range(0, 19));
        if (pick == 0)      d = 32'h1;
        else if (pick == 1) d[0] = 1'b1;
        else                d[0] = 1'b0;
        v = ($urandom_range(0, 2) != 0);
        c = ($urandom_range(0, 29) == 0);
        applyStimulus(1'b1, c, v, a, d, s);
      end
    end

    idleCycles(2);
    @(posedge clk);
    #3;
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tohost_responder.md
Name: tohost_responder

Overview:
- Memory-mapped responder on the core's data-write bus, implementing the riscv-tests tohost convention.
- The core writes a completion word to TOHOST_ADDR; the block decodes it to pass or fail and exposes sticky status plus a watchdog timeout.
- It is the hardware end of test-result signalling, so benches read status pins and no longer probe register-file internals or PC values.

Parameters:
- TOHOST_ADDR, 32'h0000_1000, byte address decoded as tohost.
- TIMEOUT_CYCLES, 5000, cycles spent in RUN before TIMEOUT is declared.
- CNT_W, 32, width of cycle and ignored-write counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- clear  in  1  synchronous restart: return to IDLE and zero all counters
- wr_valid  in  1  write request
- wr_ready  out  1  write accept
- wr_addr  in  32  byte address
- wr_data  in  32  write data
- wr_strb  in  4  byte enables
- done  out  1  sticky; high in PASS, FAIL or TIMEOUT
- pass  out  1  high only in PASS
- timeout  out  1  high only in TIMEOUT
- fail_code  out  31  wr_data[31:1] of the failing write; 0 otherwise
- cycle_count  out  CNT_W  cycles spent in RUN
- ignored_count  out  CNT_W  accepted writes that did not end the test

Behaviour:
- Reset (rst low, async):
  - State is IDLE.
  - All outputs are 0, including wr_ready, fail_code and both counters.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT.
- IDLE -> RUN on the first clk edge with rst high. wr_ready is 0 in IDLE.
- In RUN, PASS, FAIL and TIMEOUT, wr_ready is 1 every cycle. There is no backpressure after IDLE, so the core never stalls on this block.
- A write is accepted when wr_valid & wr_ready.
- Decode, RUN only, applied on the accepting edge:
  - Tohost hit requires wr_addr == TOHOST_ADDR and wr_strb == 4'hF.
  - Hit with wr_data == 1 -> PASS.
  - Hit with wr_data[0] == 1 and wr_data != 1 -> FAIL, with fail_code <= wr_data[31:1].
  - Hit with wr_data[0] == 0 (syscall/unsupported) -> stay in RUN, ignored_count += 1.
  - Any other address, or a partial strobe to TOHOST_ADDR -> stay in RUN, ignored_count += 1.
- Writes accepted in PASS, FAIL or TIMEOUT are dropped; no counter or state changes.
- cycle_count:
  - Increments every cycle in RUN and holds in all other states.
  - If cycle_count == TIMEOUT_CYCLES-1 in RUN with no terminating write, next state is TIMEOUT.
  - Saturates at all ones and never wraps; this only matters if TIMEOUT_CYCLES exceeds 2^CNT_W.
- Output latency: done, pass, timeout and fail_code are registered. They are valid the cycle after the accepting edge, i.e. one-cycle latency.
- Terminal states are sticky until rst or clear.
- Simultaneous events:
  - A terminating write on the timeout cycle takes priority; PASS/FAIL wins over TIMEOUT.
  - clear together with a write: clear wins and the write is accepted and dropped. Next state is IDLE with counters zeroed, then RUN one cycle later.
  - clear while in IDLE has no effect.
- rst asserted mid-test returns to IDLE immediately and asynchronously; outputs go to 0 without waiting for clk.
- Counters are unsigned. ignored_count saturates at all ones.

Decomposition:
- Shared package (tohost_pkg): state encoding constants, the tohost pass code (32'h1), and a decode function returning PASS, FAIL or IGNORE.
- One natural sub-module, sat_counter: a CNT_W-wide saturating counter with enable and synchronous clear. It is instantiated twice, for cycle_count and ignored_count.
- The FSM and decode live in tohost_responder.

Test Plan:
- Release rst, then write 32'h1 to 32'h1000 with strb F at cycle 10 -> next cycle done=1, pass=1, fail_code=0, cycle_count frozen at 10.
- Write 32'h0000_0007 to 32'h1000 -> done=1, pass=0, fail_code=3; a later write of 32'h1 is accepted and dropped, still FAIL.
- Writes to 32'h2000 and a strb 4'h3 write of 32'h1 to 32'h1000, then no terminating write -> ignored_count=2; after 5000 RUN cycles timeout=1, done=1, pass=0.
- Terminating write of 32'h1 landing exactly on cycle 4999 -> pass=1, timeout=0.
- From FAIL, pulse clear together with a write -> IDLE next cycle (done=0, counters 0), RUN the following cycle; then write 32'h1 -> pass=1.
- Assert rst between clock edges during RUN -> all outputs 0 immediately; wr_ready=0 until the first edge after release.
